// File: rtl/uart_tx_frame.sv
// UART serialiser: valid/ready word in, start + LSB-first data + optional parity
// + 1/2 stop bits out on a registered tx line, with an internal baud divider.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int BCNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIDX_W = $clog2(DATA_WIDTH);

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_frame: DATA_WIDTH must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 1) begin : g_bad_timing
    $error("uart_tx_frame: STOP_BITS must be 1 or 2, CLKS_PER_BIT >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                r_state, w_state_n;
  logic [BCNT_W-1:0]     r_bcnt, w_bcnt_n;
  logic [BIDX_W-1:0]     r_bidx, w_bidx_n;
  logic                  r_scnt, w_scnt_n;
  logic [DATA_WIDTH-1:0] r_shreg, w_shreg_n;
  logic                  r_par, w_par_n;
  logic                  r_tx, w_tx_n;
  logic                  r_busy, w_busy_n;
  logic                  r_done, w_done_n;
  logic                  w_tick;
  logic                  w_ready;

  assign w_tick   = (r_bcnt == BCNT_W'(CLKS_PER_BIT - 1));
  assign in_ready = w_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_scnt  <= 1'b0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_bcnt  <= w_bcnt_n;
      r_bidx  <= w_bidx_n;
      r_scnt  <= w_scnt_n;
      r_shreg <= w_shreg_n;
      r_par   <= w_par_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_bcnt_n  = r_bcnt;
    w_bidx_n  = r_bidx;
    w_scnt_n  = r_scnt;
    w_shreg_n = r_shreg;
    w_par_n   = r_par;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_ready   = 1'b0;
    w_tx_n    = 1'b1;

    // every state change happens on a tick, so wrapping here also clears on entry
    if (r_state != S_IDLE) w_bcnt_n = w_tick ? '0 : r_bcnt + BCNT_W'(1);

    case (r_state)
      S_IDLE: w_ready = 1'b1;
      S_START: begin
        if (w_tick) begin
          w_state_n = S_DATA;
          w_bidx_n  = '0;
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_shreg_n = {1'b0, r_shreg[DATA_WIDTH-1:1]};
          if (r_bidx == BIDX_W'(DATA_WIDTH - 1)) begin
            w_state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            w_scnt_n  = 1'b0;
          end else begin
            w_bidx_n = r_bidx + BIDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_state_n = S_STOP;
          w_scnt_n  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_scnt == 1'(STOP_BITS - 1)) begin
            w_ready   = 1'b1;
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
            w_busy_n  = 1'b0;
          end else begin
            w_scnt_n = r_scnt + 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // accept overrides the stop->idle move to give zero-gap back-to-back frames
    if (in_valid && w_ready) begin
      w_state_n = S_START;
      w_shreg_n = in_data;
      w_par_n   = (^in_data) ^ (PARITY_MODE == 2);
      w_bcnt_n  = '0;
      w_busy_n  = 1'b1;
    end

    case (w_state_n)
      S_START:  w_tx_n = 1'b0;
      S_DATA:   w_tx_n = w_shreg_n[0];
      S_PARITY: w_tx_n = w_par_n;
      default:  w_tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five parameterisations driven by directed and random
// words, checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_frame;

  localparam int DWS  [5] = '{8, 8, 8, 8, 5};
  localparam int CPBS [5] = '{4, 4, 4, 4, 1};
  localparam int PMS  [5] = '{1, 2, 0, 1, 0};
  localparam int SBS  [5] = '{1, 1, 1, 2, 2};

  logic       clk;
  logic       reset;
  logic [4:0] v;
  logic [8:0] d [5];
  logic [4:0] rdy, txs, busys, dones;

  int checks = 0;
  int passed = 0;
  bit exp_bits[$];

  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(reset), .in_valid(v[0]), .in_ready(rdy[0]), .in_data(d[0][7:0]),
    .tx(txs[0]), .busy(busys[0]), .done(dones[0]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset(reset), .in_valid(v[1]), .in_ready(rdy[1]), .in_data(d[1][7:0]),
    .tx(txs[1]), .busy(busys[1]), .done(dones[1]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u_nopar (
    .clk(clk), .reset(reset), .in_valid(v[2]), .in_ready(rdy[2]), .in_data(d[2][7:0]),
    .tx(txs[2]), .busy(busys[2]), .done(dones[2]));
  uart_tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset(reset), .in_valid(v[3]), .in_ready(rdy[3]), .in_data(d[3][7:0]),
    .tx(txs[3]), .busy(busys[3]), .done(dones[3]));
  uart_tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .PARITY_MODE(0), .STOP_BITS(2)) u_edge (
    .clk(clk), .reset(reset), .in_valid(v[4]), .in_ready(rdy[4]), .in_data(d[4][4:0]),
    .tx(txs[4]), .busy(busys[4]), .done(dones[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

  // Reference frame: list of line levels, one entry per serial bit.
  function automatic void build_frame(input int k, input logic [8:0] data);
    bit p;
    p = 1'b0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DWS[k]; i++) begin
      exp_bits.push_back(data[i]);
      p ^= data[i];
    end
    if (PMS[k] != 0) exp_bits.push_back((PMS[k] == 2) ? ~p : p);
    for (int i = 0; i < SBS[k]; i++) exp_bits.push_back(1'b1);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    v = '0;
    for (int k = 0; k < 5; k++) d[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (txs[k] !== 1'b1 || busys[k] !== 1'b0 || dones[k] !== 1'b0 || rdy[k] !== 1'b1)
        $display("FAIL reset_state[%0d]: tx=%b busy=%b done=%b ready=%b, want 1 0 0 1",
                 k, txs[k], busys[k], dones[k], rdy[k]);
      else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame(input int k, input logic [8:0] data, input string name);
    int f;
    int w;
    build_frame(k, data);
    f = exp_bits.size() * CPBS[k];
    w = 0;
    while (rdy[k] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rdy[k] !== 1'b1) begin
      $display("FAIL %s ready_wait: in_ready=%b, want 1", name, rdy[k]);
      return;
    end
    passed++;
    v[k] = 1'b1;
    d[k] = data;
    @(negedge clk);
    v[k] = 1'b0;
    d[k] = 9'($urandom);
    for (int c = 0; c < f; c++) begin
      checks++;
      if (txs[k] !== exp_bits[c / CPBS[k]] || busys[k] !== 1'b1 || dones[k] !== 1'b0)
        $display("FAIL %s cyc %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 name, c, txs[k], busys[k], dones[k], exp_bits[c / CPBS[k]]);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (txs[k] !== 1'b1 || busys[k] !== 1'b0 || dones[k] !== 1'b1)
      $display("FAIL %s end cyc %0d: tx=%b busy=%b done=%b, want 1 0 1",
               name, f, txs[k], busys[k], dones[k]);
    else passed++;
    @(negedge clk);
    checks++;
    if (dones[k] !== 1'b0 || txs[k] !== 1'b1)
      $display("FAIL %s after_done: done=%b tx=%b, want 0 1", name, dones[k], txs[k]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit b2b[$];
    int f;
    build_frame(3, 9'h03C);
    b2b = exp_bits;
    build_frame(3, 9'h0C3);
    b2b = {b2b, exp_bits};
    f = exp_bits.size() * CPBS[3];
    v[3] = 1'b1;
    d[3] = 9'h03C;
    @(negedge clk);
    d[3] = 9'h0C3;
    for (int c = 0; c < 2 * f; c++) begin
      checks++;
      if (txs[3] !== b2b[c / 4] || busys[3] !== 1'b1 || dones[3] !== (c == f) ||
          rdy[3] !== (c == f - 1 || c == 2 * f - 1))
        $display("FAIL b2b cyc %0d: tx=%b busy=%b done=%b ready=%b, want tx=%b busy=1 done=%b ready=%b",
                 c, txs[3], busys[3], dones[3], rdy[3], b2b[c / 4], c == f,
                 (c == f - 1 || c == 2 * f - 1));
      else passed++;
      if (c == f) v[3] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (txs[3] !== 1'b1 || busys[3] !== 1'b0 || dones[3] !== 1'b1)
      $display("FAIL b2b end: tx=%b busy=%b done=%b, want 1 0 1", txs[3], busys[3], dones[3]);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_busy_reject();
    int f;
    build_frame(0, 9'h05A);
    f = exp_bits.size() * 4;
    v[0] = 1'b1;
    d[0] = 9'h05A;
    @(negedge clk);
    v[0] = 1'b0;
    for (int c = 0; c < f; c++) begin
      checks++;
      if (txs[0] !== exp_bits[c / 4] || busys[0] !== 1'b1 || dones[0] !== 1'b0)
        $display("FAIL reject cyc %0d: tx=%b busy=%b done=%b, want tx=%b busy=1 done=0",
                 c, txs[0], busys[0], dones[0], exp_bits[c / 4]);
      else passed++;
      if (c == 10) begin
        checks++;
        if (rdy[0] !== 1'b0) $display("FAIL reject ready_mid: in_ready=%b, want 0", rdy[0]);
        else passed++;
        v[0] = 1'b1;
        d[0] = 9'h0FF;
      end
      if (c == 11) v[0] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (dones[0] !== 1'b1 || busys[0] !== 1'b0)
      $display("FAIL reject end: done=%b busy=%b, want 1 0", dones[0], busys[0]);
    else passed++;
    for (int c = 0; c < 2 * f; c++) begin
      @(negedge clk);
      checks++;
      if (txs[0] !== 1'b1 || busys[0] !== 1'b0 || dones[0] !== 1'b0)
        $display("FAIL reject idle cyc %0d: tx=%b busy=%b done=%b, want 1 0 0",
                 c, txs[0], busys[0], dones[0]);
      else passed++;
    end
    test_frame(0, 9'h0FF, "reject_ff");
  endtask

  task automatic test_reset_mid_frame();
    build_frame(0, 9'h096);
    v[0] = 1'b1;
    d[0] = 9'h096;
    @(negedge clk);
    v[0] = 1'b0;
    for (int c = 0; c < 17; c++) begin
      checks++;
      if (txs[0] !== exp_bits[c / 4])
        $display("FAIL rstmid cyc %0d: tx=%b, want %b", c, txs[0], exp_bits[c / 4]);
      else passed++;
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (txs[0] !== 1'b1 || busys[0] !== 1'b0 || dones[0] !== 1'b0)
      $display("FAIL rstmid async: tx=%b busy=%b done=%b, want 1 0 0", txs[0], busys[0], dones[0]);
    else passed++;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dones[0] !== 1'b0 || txs[0] !== 1'b1)
        $display("FAIL rstmid held: done=%b tx=%b, want 0 1", dones[0], txs[0]);
      else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[0] !== 1'b1 || dones[0] !== 1'b0)
      $display("FAIL rstmid release: ready=%b done=%b, want 1 0", rdy[0], dones[0]);
    else passed++;
    test_frame(0, 9'h03B, "rstmid_fresh");

    reset = 1'b1;
    v[4] = 1'b1;
    d[4] = 9'h01F;
    @(negedge clk);
    v[4] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (txs[4] !== 1'b1 || busys[4] !== 1'b0)
      $display("FAIL rst_vs_accept: tx=%b busy=%b, want 1 0", txs[4], busys[4]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_frame(0, 9'h0A5, "even_a5");
    test_frame(1, 9'h007, "odd_07");
    test_frame(0, 9'h007, "even_07");
    test_frame(2, 9'h007, "nopar_07");
    test_frame(4, 9'h015, "edge_15");
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_frame();
    for (int i = 0; i < 15; i++) test_frame(i % 5, 9'($urandom), $sformatf("rand%0d", i));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
